// File: rtl/problema1_button_pkg.sv
// Shared register map and debounce FSM encoding for the push-button controller.
package problema1_button_pkg;

   localparam int NUM_BUTTONS = 4;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_COUNTING = 1'b1
   } deb_state_t;

   function automatic logic [31:0] zext4(input logic [3:0] value);
      return {28'd0, value};
   endfunction

endpackage

// File: rtl/problema1_debounce.sv
// One button lane: 2-flop synchronizer, stability counter/FSM, and a press pulse
// issued together with the debounced 1->0 transition.
module problema1_debounce
   import problema1_button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic db,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             db_reg;
   logic             press_reg;
   logic [CNT_W-1:0] count_reg;
   deb_state_t       state_reg;

   // Entering COUNTING already counts the first mismatching cycle, so d changes
   // exactly DEBOUNCE_CYCLES cycles after the synchronized input does.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         db_reg    <= 1'b1;
         press_reg <= 1'b0;
         count_reg <= '0;
         state_reg <= ST_STABLE;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
         press_reg <= 1'b0;
         case (state_reg)
            ST_STABLE: begin
               if (sync2_reg != db_reg) begin
                  state_reg <= ST_COUNTING;
                  count_reg <= CNT_W'(1);
               end
            end
            ST_COUNTING: begin
               if (sync2_reg == db_reg) begin
                  state_reg <= ST_STABLE;
                  count_reg <= '0;
               end else if (count_reg == CNT_LAST) begin
                  db_reg    <= sync2_reg;
                  press_reg <= db_reg;
                  count_reg <= '0;
                  state_reg <= ST_STABLE;
               end else begin
                  count_reg <= count_reg + CNT_W'(1);
               end
            end
            default: begin
               state_reg <= ST_STABLE;
               count_reg <= '0;
            end
         endcase
      end
   end

   assign db    = db_reg;
   assign press = press_reg;

endmodule

// File: rtl/problema1_button_ctrl.sv
// Avalon-MM push-button peripheral: four debounced inputs, press capture with
// write-1-to-clear, interrupt mask and a level interrupt.
module problema1_button_ctrl
   import problema1_button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [3:0]  in_port,
   output logic        irq
);

   logic [NUM_BUTTONS-1:0] db;
   logic [NUM_BUTTONS-1:0] press;
   logic [3:0]             mask_reg;
   logic [3:0]             edge_reg;
   logic [3:0]             edge_next;
   logic [3:0]             clear_bits;
   logic [31:0]            readdata_reg;
   logic [31:0]            read_mux;
   logic                   wr_en;
   logic                   unused_wdata;

   generate
      for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
         problema1_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
         ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (in_port[gi]),
            .db     (db[gi]),
            .press  (press[gi])
         );
      end
   endgenerate

   assign wr_en        = chipselect & ~write_n;
   assign unused_wdata = ^writedata[31:4];

   // Press is OR-ed in after the clear so a simultaneous event is never lost.
   always_comb begin
      clear_bits = '0;
      if (wr_en && address == ADDR_EDGE) begin
         clear_bits = writedata[3:0];
      end
      edge_next = (edge_reg & ~clear_bits) | press;
   end

   always_comb begin
      read_mux = '0;
      case (address)
         ADDR_DATA: read_mux = zext4(db);
         ADDR_MASK: read_mux = zext4(mask_reg);
         ADDR_EDGE: read_mux = zext4(edge_reg);
         default:   read_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_reg     <= '0;
         edge_reg     <= '0;
         readdata_reg <= '0;
      end else begin
         if (wr_en && address == ADDR_MASK) begin
            mask_reg <= writedata[3:0];
         end
         edge_reg     <= edge_next;
         readdata_reg <= read_mux;
      end
   end

   assign readdata = readdata_reg;
   assign irq      = |(edge_reg & mask_reg);

endmodule

// File: tb/tb_problema1_button_ctrl.sv
// Directed bench for the push-button controller with DEBOUNCE_CYCLES=4.
module tb_problema1_button_ctrl;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  in_port;
   logic        irq;

   int tests_run = 0;
   int tests_failed = 0;

   problema1_button_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
      $display("[TB] check %s observed=0x%08h expected=0x%08h", tag, observed, expected);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Present an address, wait one edge for the registered read, compare.
   task automatic read_chk(input logic [1:0] addr, input logic [31:0] expected, input string tag);
      address = addr;
      @(negedge clk);
      check(tag, readdata, expected);
   endtask

   task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
      address    = addr;
      writedata  = data;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 4'hF;
      cycles(3);
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", {31'd0, irq}, 32'h0);
      reset_n = 1'b1;
      cycles(2);

      // Idle register values after reset
      read_chk(2'd0, 32'h0000000F, "idle_data");
      read_chk(2'd2, 32'h0, "idle_mask");
      read_chk(2'd3, 32'h0, "idle_edge");
      check("idle_irq", {31'd0, irq}, 32'h0);

      // Press bit 0: d must fall exactly 6 cycles after the pin (seen 1 later on readdata)
      address = 2'd0;
      @(negedge clk);
      in_port = 4'hE;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check($sformatf("lat_pre%0d", k), readdata, 32'h0000000F);
      end
      @(negedge clk);
      check("lat_d0", readdata, 32'h0000000E);
      read_chk(2'd3, 32'h1, "press0_edge");
      check("press0_irq_masked", {31'd0, irq}, 32'h0);
      write_reg(2'd2, 32'h1);
      check("unmask_irq", {31'd0, irq}, 32'h1);
      read_chk(2'd2, 32'h1, "mask_rd");

      // Release bit 0: no event
      in_port = 4'hF;
      cycles(10);
      read_chk(2'd0, 32'h0000000F, "release0_data");
      read_chk(2'd3, 32'h1, "release0_edge");

      // Bounce on bit 1 twice; the gap must clear the counter
      in_port = 4'hD;
      cycles(3);
      in_port = 4'hF;
      cycles(2);
      in_port = 4'hD;
      cycles(3);
      in_port = 4'hF;
      cycles(10);
      read_chk(2'd0, 32'h0000000F, "bounce_data");
      read_chk(2'd3, 32'h1, "bounce_edge");

      // Real press on bit 1, then W1C bit 0
      in_port = 4'hD;
      cycles(10);
      read_chk(2'd3, 32'h3, "press1_edge");
      write_reg(2'd3, 32'h1);
      check("w1c0_irq", {31'd0, irq}, 32'h0);
      read_chk(2'd3, 32'h2, "w1c0_edge");
      write_reg(2'd3, 32'h2);
      read_chk(2'd3, 32'h0, "w1c1_edge");

      // Release bit 1, re-press with W1C landing on the same edge as the capture
      in_port = 4'hF;
      cycles(10);
      in_port = 4'hD;
      cycles(6);
      write_reg(2'd3, 32'h2);
      read_chk(2'd3, 32'h2, "race_set_wins");
      in_port = 4'hF;
      cycles(10);
      write_reg(2'd3, 32'h2);
      read_chk(2'd3, 32'h0, "race_cleanup");

      // Bit 2 press/release; mask changes leave capture untouched
      in_port = 4'hB;
      cycles(10);
      read_chk(2'd3, 32'h4, "press2_edge");
      check("press2_irq_masked", {31'd0, irq}, 32'h0);
      write_reg(2'd2, 32'h4);
      check("mask4_irq", {31'd0, irq}, 32'h1);
      write_reg(2'd2, 32'h0);
      check("mask0_irq", {31'd0, irq}, 32'h0);
      read_chk(2'd3, 32'h4, "mask_keeps_edge");
      write_reg(2'd3, 32'h4);
      in_port = 4'hF;
      cycles(10);
      read_chk(2'd3, 32'h0, "release2_edge");
      write_reg(2'd1, 32'hF);
      write_reg(2'd0, 32'h0);
      read_chk(2'd1, 32'h0, "rsvd_rd");
      read_chk(2'd0, 32'h0000000F, "data_ro");

      // Reset mid-count on bit 3
      in_port = 4'h7;
      cycles(3);
      reset_n = 1'b0;
      cycles(2);
      check("midrst_readdata", readdata, 32'h0);
      check("midrst_irq", {31'd0, irq}, 32'h0);
      address = 2'd3;
      reset_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         check($sformatf("postrst_edge%0d", k), readdata, 32'h0);
      end
      @(negedge clk);
      check("postrst_capture", readdata, 32'h8);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
